// File: rtl/err_test_pkg.sv
// Shared definitions for the error-line stimulus generator and its neighbours.
// Holds the FSM state encoding, default widths and a small helper.
package err_test_pkg;

  // Default width of hold_us and the microsecond counter.
  localparam int unsigned DWIDTH_DEFAULT = 14;
  // Default width of glitch_num and the glitch counter.
  localparam int unsigned NUM_W_DEFAULT  = 4;

  // State encoding: IDLE=0 .. DONE=4.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StGHi  = 3'd1,
    StGLo  = 3'd2,
    StHold = 3'd3,
    StDone = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/err_pulse_gen_us_tick_sync.sv
// Microsecond timebase synchronizer.
// Brings the asynchronous 1 us strobe into the clk domain through two flops and
// emits a one-cycle tick on its rising edge.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   time_1us_i asynchronous 1 us strobe
//   tick_o     one-cycle pulse per rising edge of time_1us_i
module us_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic time_1us_i,
  output logic tick_o
);

  // sync_q[0] is the newest sample, sync_q[1] the previous one.
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], time_1us_i};
    end
  end

  assign tick_o = (sync_q == 2'b01);

endmodule

// File: rtl/err_pulse_gen.sv
// Error-line stimulus generator.
// On start it drives glitch_num short high pulses (GLITCH_CLKS high, GAP_CLKS
// low each), then holds the line high for hold_us microsecond ticks, then
// pulses done. Used to exercise the downstream error detector/debouncer.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   time_1us   asynchronous 1 us timebase strobe
//   reset_unit synchronous abort, active high, beats start
//   start      one-cycle start request, ignored unless idle
//   glitch_num number of glitches before the hold phase (0 allowed)
//   hold_us    hold-high duration in us (0 allowed)
//   signal_out generated error line (registered)
//   busy       high from the accepted start until the return to idle
//   done       one-cycle pulse on normal completion
module err_pulse_gen
  import err_test_pkg::*;
#(
  parameter int unsigned GLITCH_CLKS = 2,
  parameter int unsigned GAP_CLKS    = 3,
  parameter int unsigned NUM_W       = NUM_W_DEFAULT,
  parameter int unsigned DWIDTH      = DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              time_1us,
  input  logic              reset_unit,
  input  logic              start,
  input  logic [NUM_W-1:0]  glitch_num,
  input  logic [DWIDTH-1:0] hold_us,
  output logic              signal_out,
  output logic              busy,
  output logic              done
);

  // One phase counter serves both the high and the low part of a glitch.
  localparam int unsigned PhMax = max_u(GLITCH_CLKS, GAP_CLKS);
  localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;
  localparam logic [PhW-1:0] GlitchLast = PhW'(GLITCH_CLKS - 1);
  localparam logic [PhW-1:0] GapLast    = PhW'(GAP_CLKS - 1);

  logic tick;

  us_tick_sync u_tick_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_1us_i (time_1us),
    .tick_o     (tick)
  );

  state_e              state_q, state_d;
  logic [NUM_W-1:0]    glitch_num_q, glitch_num_d;
  logic [DWIDTH-1:0]   hold_us_q, hold_us_d;
  logic [NUM_W-1:0]    glitch_cnt_q, glitch_cnt_d;
  logic [DWIDTH-1:0]   us_cnt_q, us_cnt_d;
  logic [PhW-1:0]      phase_q, phase_d;
  // Set when a run with nothing to do was accepted: it still shows one busy
  // cycle before the done pulse, so DONE is occupied for two cycles.
  logic                empty_q, empty_d;
  logic                signal_q, signal_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NUM_W-1:0]    glitch_inc;
  logic [DWIDTH-1:0]   us_inc;
  logic [PhW-1:0]      phase_inc;

  assign glitch_inc = glitch_cnt_q + NUM_W'(1);
  assign us_inc     = us_cnt_q + DWIDTH'(1);
  assign phase_inc  = phase_q + PhW'(1);

  // Outputs are computed for the next state so they register together with it.
  always_comb begin
    state_d      = state_q;
    glitch_num_d = glitch_num_q;
    hold_us_d    = hold_us_q;
    glitch_cnt_d = glitch_cnt_q;
    us_cnt_d     = us_cnt_q;
    phase_d      = phase_q;
    empty_d      = empty_q;
    signal_d     = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          glitch_num_d = glitch_num;
          hold_us_d    = hold_us;
          glitch_cnt_d = '0;
          us_cnt_d     = '0;
          phase_d      = '0;
          busy_d       = 1'b1;
          if (glitch_num != '0) begin
            state_d  = StGHi;
            signal_d = 1'b1;
          end else if (hold_us != '0) begin
            state_d  = StHold;
            signal_d = 1'b1;
          end else begin
            state_d = StDone;
            empty_d = 1'b1;
          end
        end
      end

      StGHi: begin
        busy_d = 1'b1;
        if (phase_q == GlitchLast) begin
          phase_d = '0;
          state_d = StGLo;
        end else begin
          phase_d  = phase_inc;
          signal_d = 1'b1;
        end
      end

      StGLo: begin
        busy_d = 1'b1;
        if (phase_q == GapLast) begin
          phase_d      = '0;
          glitch_cnt_d = glitch_inc;
          if (glitch_inc == glitch_num_q) begin
            if (hold_us_q != '0) begin
              state_d  = StHold;
              signal_d = 1'b1;
            end else begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            state_d  = StGHi;
            signal_d = 1'b1;
          end
        end else begin
          phase_d = phase_inc;
        end
      end

      StHold: begin
        busy_d   = 1'b1;
        signal_d = 1'b1;
        if (tick) begin
          us_cnt_d = us_inc;
          if (us_inc == hold_us_q) begin
            state_d  = StDone;
            signal_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end

      StDone: begin
        if (empty_q) begin
          empty_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (reset_unit) begin
      state_d      = StIdle;
      glitch_cnt_d = '0;
      us_cnt_d     = '0;
      phase_d      = '0;
      empty_d      = 1'b0;
      signal_d     = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      glitch_num_q <= '0;
      hold_us_q    <= '0;
      glitch_cnt_q <= '0;
      us_cnt_q     <= '0;
      phase_q      <= '0;
      empty_q      <= 1'b0;
      signal_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      glitch_num_q <= glitch_num_d;
      hold_us_q    <= hold_us_d;
      glitch_cnt_q <= glitch_cnt_d;
      us_cnt_q     <= us_cnt_d;
      phase_q      <= phase_d;
      empty_q      <= empty_d;
      signal_q     <= signal_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign signal_out = signal_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_err_pulse_gen.sv
// Bench for err_pulse_gen: 50 MHz clock, 1 us strobe every 50 clocks.
// Per-cycle expectations of {signal_out, busy, done} are queued when a run is
// launched and popped at each falling edge; the hold phase is checked against
// its allowed length window.
module tb_err_pulse_gen;

  logic        clk;
  logic        rst_n;
  logic        time_1us;
  logic        reset_unit;
  logic        start;
  logic [3:0]  glitch_num;
  logic [13:0] hold_us;
  logic        signal_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fails  = 0;

  err_pulse_gen #(
    .GLITCH_CLKS (2),
    .GAP_CLKS    (3),
    .NUM_W       (4),
    .DWIDTH      (14)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_1us   (time_1us),
    .reset_unit (reset_unit),
    .start      (start),
    .glitch_num (glitch_num),
    .hold_us    (hold_us),
    .signal_out (signal_out),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // 1 us strobe, one clock wide, offset so it never lands on a clock edge.
  initial begin
    time_1us = 1'b0;
    #7;
    forever begin
      #980;
      time_1us = 1'b1;
      #20;
      time_1us = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] obs();
    return {signal_out, busy, done};
  endfunction

  // Launch a run and check it. inject_at: cycle at which a second start with
  // other values is driven. abort_at: cycle after which reset_unit is pulsed.
  task automatic run_seq(input string tag, input int gn, input int hu,
                         input int inject_at, input int abort_at);
    logic [2:0] exp_q[$];
    logic [2:0] e;
    int         cyc_i;
    int         hold_n;
    int         stray;
    bit         aborted;
    bit         len_ok;
    aborted = 1'b0;
    for (int g = 0; g < gn; g++) begin
      repeat (2) exp_q.push_back(3'b110);
      repeat (3) exp_q.push_back(3'b010);
    end
    if (hu == 0) begin
      if (gn == 0) exp_q.push_back(3'b010);
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b000);
    end
    glitch_num = 4'(gn);
    hold_us    = 14'(hu);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc_i = 1;
    while (exp_q.size() > 0 && !aborted) begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s cyc%0d", tag, cyc_i), 32'(obs()), 32'(e));
      start = (cyc_i == inject_at);
      if (cyc_i == inject_at) begin
        glitch_num = 4'd7;
        hold_us    = 14'd9;
      end
      if (cyc_i == abort_at) begin
        reset_unit = 1'b1;
        aborted    = 1'b1;
      end
      @(negedge clk);
      cyc_i++;
    end
    start = 1'b0;
    if (aborted) begin
      reset_unit = 1'b0;
      check_eq($sformatf("%s abort", tag), 32'(obs()), 32'd0);
      stray = 0;
      repeat (200) begin
        @(negedge clk);
        if (obs() != 3'b000) stray++;
      end
      check_eq($sformatf("%s quiet_after_abort", tag), 32'(stray), 32'd0);
    end else if (hu != 0) begin
      hold_n = 0;
      while (obs() == 3'b110 && hold_n < hu * 50 + 20) begin
        hold_n++;
        @(negedge clk);
      end
      len_ok = (hold_n >= (hu - 1) * 50) && (hold_n <= hu * 50 + 2);
      check_eq($sformatf("%s hold_len_ok(len=%0d)", tag, hold_n), 32'(len_ok), 32'd1);
      check_eq($sformatf("%s done", tag), 32'(obs()), 32'(3'b001));
      @(negedge clk);
      check_eq($sformatf("%s idle", tag), 32'(obs()), 32'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    reset_unit = 1'b0;
    start      = 1'b0;
    glitch_num = '0;
    hold_us    = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_after_reset", 32'(obs()), 32'd0);

    // Abort beats a simultaneous start.
    glitch_num = 4'd3;
    start      = 1'b1;
    reset_unit = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    reset_unit = 1'b0;
    check_eq("abort_beats_start", 32'(obs()), 32'd0);
    @(negedge clk);
    check_eq("abort_beats_start_idle", 32'(obs()), 32'd0);

    run_seq("g3h0", 3, 0, -1, -1);
    run_seq("g0h5", 0, 5, -1, -1);
    run_seq("g2h3_abort", 2, 3, -1, 6);
    run_seq("g2h3_rerun", 2, 3, -1, -1);
    run_seq("g3h2_busy_start", 3, 2, 4, -1);
    run_seq("g0h0", 0, 0, -1, -1);
    run_seq("g15h0", 15, 0, -1, -1);
    run_seq("g1h1", 1, 1, -1, -1);

    // Asynchronous reset in the middle of the hold phase.
    glitch_num = 4'd0;
    hold_us    = 14'd5;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("rst_hold_rise", 32'(obs()), 32'(3'b110));
    repeat (100) @(negedge clk);
    check_eq("rst_hold_mid", 32'(obs()), 32'(3'b110));
    #3 rst_n = 1'b0;
    #1 check_eq("rst_async_clear", 32'(obs()), 32'd0);
    @(negedge clk);
    check_eq("rst_held", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_released_idle", 32'(obs()), 32'd0);
    run_seq("after_rst_g0h2", 0, 2, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/err_pulse_gen.md
Name: err_pulse_gen

Overview:
Test-stimulus generator for the error-line detection path on the PCB test fixture.
- On command it drives a programmable burst of short glitches on a single error line, then a sustained high level timed in microseconds.
- Its output feeds the high-level error detector/debouncer, so that detector's rejection and acceptance thresholds can be exercised in-system.
- Sits beside the detector and is controlled by the test sequencer.

Parameters:
GLITCH_CLKS, 2, width of each glitch high phase in clk cycles (≥1)
GAP_CLKS, 3, low time after each glitch in clk cycles (≥1)
NUM_W, 4, width of glitch_num
DWIDTH, 14, width of hold_us and the hold counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
time_1us  in  1  1 µs timebase strobe, asynchronous to clk logic, synchronized internally
reset_unit  in  1  synchronous abort, active high
start  in  1  one-cycle start request
glitch_num  in  NUM_W  number of glitches before the hold phase (0 allowed)
hold_us  in  DWIDTH  hold-high duration in µs (0 allowed)
signal_out  out  1  generated error line, registered
busy  out  1  high from the accepted start until the return to IDLE
done  out  1  one-cycle pulse on normal completion

Behaviour:
Interface: one clock (clk); reset rst_n is asynchronous and active-low.

Reset values:
- rst_n low gives signal_out=0, busy=0, done=0, state=IDLE, all counters 0, and sync regs 0.

Timebase:
- time_1us passes through a 2-flop sync (sync[1:0] <= {sync[0], time_1us}).
- tick = sync==2'b01, i.e. a rising edge, one cycle wide.

FSM states: IDLE, G_HI, G_LO, HOLD, DONE.

IDLE:
- start=1 latches glitch_num and hold_us.
- Next state is G_HI if glitch_num≠0; else HOLD if hold_us≠0; else DONE.
- busy=1 from the next edge.

G_HI:
- signal_out=1 for exactly GLITCH_CLKS cycles, then go to G_LO.

G_LO:
- signal_out=0 for exactly GAP_CLKS cycles.
- Then the glitch counter increments.
- If the count equals the latched glitch_num, go to HOLD if hold_us≠0, else DONE. Otherwise go to G_HI.

HOLD:
- signal_out=1.
- The µs counter increments only on ticks sampled while in HOLD.
- When the counter reaches the latched hold_us, go to DONE.
- Hold width lies in (hold_us−1, hold_us] µs, plus sync latency.

DONE:
- One cycle with signal_out=0, done=1, busy=0.
- Then IDLE.

Output timing:
- signal_out is a registered function of the next state, so the first glitch rises on the first edge after start is sampled (latency 1).

Control rules:
- start while busy is ignored; latched values are unchanged.
- reset_unit=1 in any state goes to IDLE on that edge with signal_out=0, busy=0, done=0, and counters cleared. No done pulse.
- reset_unit wins over a simultaneous start.

Counter widths:
- Glitch counter is NUM_W bits; µs counter is DWIDTH bits.
- Compares are on equality, so the maximum values 15 and 16383 are legal with no wrap.

Other boundary conditions:
- Changes on glitch_num/hold_us inputs mid-run have no effect.
- rst_n assertion mid-run clears everything immediately, asynchronously.

Decomposition:
Shared package (err_test_pkg) holds:
- FSM state encoding localparams (IDLE=0…DONE=4).
- Default DWIDTH=14.

Natural sub-module: us_tick_sync.
- 2-flop synchronizer plus rising-edge detect producing tick.
- Reusable by the detector path.

Test Plan:
Conditions: clk 50 MHz, time_1us pulse every 50 clk.
- start, glitch_num=3, hold_us=0:
  - signal_out shows 3 highs of 2 clk, each followed by 3 clk low.
  - done pulses at cycle 16 after start; busy high cycles 1–15.
- start, glitch_num=0, hold_us=5:
  - signal_out rises at cycle 1 and stays high 4–5 µs.
  - Then done=1 for one cycle; no glitches seen.
- start, glitch_num=2, hold_us=3, reset_unit asserted during the 2nd G_HI:
  - signal_out=0, busy=0 the next edge; done never asserts.
  - A new start afterwards runs the full sequence normally.
- start again while busy, with different glitch_num/hold_us:
  - Ignored; the waveform matches the original latched values.
- glitch_num=0, hold_us=0:
  - signal_out stays 0.
  - busy high 1 cycle, done pulses 2 cycles after start.
- rst_n low mid-HOLD:
  - signal_out/busy/done drop to 0 asynchronously.
  - After release, state is IDLE and tick history is cleared (no spurious tick on the first cycle).
